request_output_arb: RTL and testbench
=====================================

REQUEST_OUTPUT_ARB -- requirements
Module: request_output_arb

Interface
REQ-001 Parameter NCHAN, default 2, number of request channels (1..16).
REQ-002 Parameter DATA_W, default 32, payload width per channel.
REQ-003 Parameter TAG_W, default 32, tag width in the output word.
REQ-004 Parameter DEPTH, default 4, output buffer entries (power of 2, >=2).
REQ-005 Parameter TAG_BASE, default 1, tag of channel 0; channel i uses TAG_BASE+i.
REQ-006 CLK  in  1  single clock, all state on rising edge.
REQ-007 nRST  in  1  reset, asynchronous and active-low.
REQ-008 request_ENA  in  NCHAN  per-channel method enable.
REQ-009 request_v  in  NCHAN*DATA_W  per-channel payload; channel i at bits [i*DATA_W +: DATA_W].
REQ-010 request_RDY  out  NCHAN  per-channel method ready.
REQ-011 pipe_enq__ENA  out  1  output word valid.
REQ-012 pipe_enq_v  out  TAG_W+DATA_W  output word {tag, payload}.
REQ-013 pipe_enq__RDY  in  1  downstream ready.
REQ-014 count  out  log2(DEPTH)+1  current buffer occupancy.

Function
REQ-015 Priority order each cycle SHALL start at round-robin pointer rr and wrap cyclically through NCHAN-1 to 0.
REQ-016 request_RDY[i] SHALL be 1 iff buffer not full and no channel earlier in the current priority order asserts request_ENA; it SHALL NOT depend on request_ENA[i] or pipe_enq__RDY.
REQ-017 Accept on channel i = request_ENA[i] && request_RDY[i]; at most one accept per cycle.
REQ-018 Channels that assert ENA without RDY SHALL be ignored (no capture, no state change).
REQ-019 On accept of channel g, entry {TAG_BASE+g truncated to TAG_W, payload g} SHALL be written at the tail and rr SHALL become (g+1) mod NCHAN; without accept rr holds.
REQ-020 pipe_enq__ENA SHALL equal (count != 0); pipe_enq_v SHALL be the head entry, registered, stable while pipe_enq__ENA && !pipe_enq__RDY.
REQ-021 Pop when pipe_enq__ENA && pipe_enq__RDY; head pointer advances.
REQ-022 Latency: word accepted in cycle t SHALL be presentable at pipe_enq_v in cycle t+1 when the buffer was empty.
REQ-023 Order: words SHALL leave in acceptance order.
REQ-024 Simultaneous push and pop: count unchanged, both pointers advance; permitted at any occupancy where push is allowed.
REQ-025 Full (count==DEPTH): all request_RDY 0 even if a pop occurs this cycle.
REQ-026 Pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH; count SHALL never exceed DEPTH nor underflow.
REQ-027 NCHAN==1: rr constant 0, request_RDY[0] = !full.

Reset
REQ-028 nRST low SHALL asynchronously clear head, tail, count, rr to 0; pipe_enq__ENA 0; request_RDY all 1 (subject to REQ-016).
REQ-029 Reset mid-operation SHALL discard all buffered words; buffer storage contents need no reset.
REQ-030 First accept is possible in the first cycle after nRST deasserts.

Structure
REQ-031 Package request_output_pkg SHALL hold the output-word struct typedef (tag, data) and the default tag width/base constants.
REQ-032 Buffer SHALL be one sub-module request_output_fifo (parametrised width/depth, push/pop/full/empty/count); arbiter and tag formation stay in request_output_arb.

Verification
REQ-033 Reset, ENA[0]=1 v0=0x11 one cycle, pipe RDY=1 -> next cycle pipe_enq__ENA=1, pipe_enq_v={1,0x11}, then empty.
REQ-034 NCHAN=2, both ENA continuously, v0=0xA, v1=0xB, pipe RDY=1 -> output tags alternate 1,2,1,2 starting with 1.
REQ-035 DEPTH=4, pipe RDY=0, ENA[0] with 6 words -> 4 accepted, RDY[0]=0 at count=4; raise RDY -> 4 words out in order, then remaining 2.
REQ-036 Full buffer, pipe RDY=1 and ENA[1]=1 same cycle -> pop occurs, no push, count 3; push next cycle.
REQ-037 NCHAN=4, TAG_BASE=8, ENA on channels 1 and 3 only -> tags 9,11 alternating; rr skips idle channels.
REQ-038 Assert nRST low with 3 buffered words while pipe RDY=0 -> pipe_enq__ENA=0 immediately (asynchronous), count=0, after release no stale word emitted.

Source files
------------

// File: rtl/request_output_pkg.sv
// request_output_pkg: shared output-word layout and default tag constants
package request_output_pkg;
   localparam int DEF_TAG_W    = 32;
   localparam int DEF_TAG_BASE = 1;
   localparam int DEF_DATA_W   = 32;
   typedef struct packed {
      logic [DEF_TAG_W-1:0]  tag;
      logic [DEF_DATA_W-1:0] data;
   } out_word_t;
endpackage

// File: rtl/request_output_fifo.sv
// request_output_fifo: power-of-2 circular buffer with occupancy count
module request_output_fifo
   import request_output_pkg::*;
#(
   parameter int W     = DEF_TAG_W + DEF_DATA_W,
   parameter int DEPTH = 4
) (
   input  logic                      CLK,
   input  logic                      nRST,
   input  logic                      push,
   input  logic                      pop,
   input  logic [W-1:0]              din,
   output logic [W-1:0]              dout,
   output logic                      full,
   output logic                      empty,
   output logic [$clog2(DEPTH):0]    count
);
   localparam int AW = $clog2(DEPTH);
   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] head, tail;
   logic          do_push, do_pop;
   assign full    = count == (AW+1)'(DEPTH);
   assign empty   = count == '0;
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[head];
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (do_push) tail <= tail + 1'b1;
         if (do_pop) head <= head + 1'b1;
         count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
      end
   end
   // storage is deliberately unreset; occupancy alone decides what is valid
   always_ff @(posedge CLK) begin
      if (do_push) mem[tail] <= din;
   end
endmodule

// File: rtl/request_output_arb.sv
// request_output_arb: round-robin arbiter tagging channel payloads into an output buffer
module request_output_arb
   import request_output_pkg::*;
#(
   parameter int NCHAN    = 2,
   parameter int DATA_W   = 32,
   parameter int TAG_W    = DEF_TAG_W,
   parameter int DEPTH    = 4,
   parameter int TAG_BASE = DEF_TAG_BASE
) (
   input  logic                      CLK,
   input  logic                      nRST,
   input  logic [NCHAN-1:0]          request_ENA,
   input  logic [NCHAN*DATA_W-1:0]   request_v,
   output logic [NCHAN-1:0]          request_RDY,
   output logic                      pipe_enq__ENA,
   output logic [TAG_W+DATA_W-1:0]   pipe_enq_v,
   input  logic                      pipe_enq__RDY,
   output logic [$clog2(DEPTH):0]    count
);
   localparam int RW = NCHAN > 1 ? $clog2(NCHAN) : 1;
   logic [RW-1:0]           rr, rr_nxt;
   logic [NCHAN-1:0]        rot, rdy_rot;
   logic                    full, empty, seen, accept;
   logic [DATA_W-1:0]       pay;
   logic [TAG_W+DATA_W-1:0] din;
   int                      pk, gi;
   // rotate so that position 0 is the channel at rr, then rotate readiness back
   always_comb begin
      rot     = NCHAN'({request_ENA, request_ENA} >> rr);
      rdy_rot = '0;
      seen    = 1'b0;
      pk      = 0;
      for (int k = 0; k < NCHAN; k++) begin
         rdy_rot[k] = !full && !seen;
         if (rot[k] && !seen) pk = k;
         seen = seen | rot[k];
      end
      request_RDY = NCHAN'(({rdy_rot, rdy_rot} << rr) >> NCHAN);
      accept      = seen && !full;
      gi          = int'(rr) + pk >= NCHAN ? int'(rr) + pk - NCHAN : int'(rr) + pk;
      rr_nxt      = gi + 1 == NCHAN ? '0 : RW'(gi + 1);
      pay         = DATA_W'(request_v >> (gi * DATA_W));
      din         = {TAG_W'(TAG_BASE + gi), pay};
   end
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) rr <= '0;
      else if (accept) rr <= rr_nxt;
   end
   assign pipe_enq__ENA = !empty;
   request_output_fifo #(.W(TAG_W + DATA_W), .DEPTH(DEPTH)) u_fifo (
      .CLK   (CLK),
      .nRST  (nRST),
      .push  (accept),
      .pop   (pipe_enq__RDY),
      .din   (din),
      .dout  (pipe_enq_v),
      .full  (full),
      .empty (empty),
      .count (count)
   );
endmodule

// File: tb/tb_request_output_arb.sv
// tb_request_output_arb: directed and random checks against a queue-based reference model
module tb_request_output_arb;
   localparam int NCHAN = 4, DATA_W = 16, TAG_W = 8, DEPTH = 4, TAG_BASE = 8;
   localparam int W = TAG_W + DATA_W;
   logic                    CLK = 1'b0, nRST = 1'b0;
   logic [NCHAN-1:0]        request_ENA = '0, request_RDY;
   logic [NCHAN*DATA_W-1:0] request_v = '0;
   logic                    pipe_enq__ENA, pipe_enq__RDY = 1'b0;
   logic [W-1:0]            pipe_enq_v;
   logic [2:0]              count;
   int                      n_chk = 0, n_fail = 0;
   logic [W-1:0]            q[$];
   int                      rr = 0;

   always #5 CLK = ~CLK;

   request_output_arb #(.NCHAN(NCHAN), .DATA_W(DATA_W), .TAG_W(TAG_W), .DEPTH(DEPTH),
                        .TAG_BASE(TAG_BASE)) dut (
      .CLK           (CLK),
      .nRST          (nRST),
      .request_ENA   (request_ENA),
      .request_v     (request_v),
      .request_RDY   (request_RDY),
      .pipe_enq__ENA (pipe_enq__ENA),
      .pipe_enq_v    (pipe_enq_v),
      .pipe_enq__RDY (pipe_enq__RDY),
      .count         (count)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int pos(input int i);
      return (i - rr + NCHAN) % NCHAN;
   endfunction

   task automatic step(input logic [NCHAN-1:0] ena, input logic [63:0] v, input logic prdy);
      logic [NCHAN-1:0] er;
      int               best;
      bit               full, blk;
      @(negedge CLK);
      request_ENA   = ena;
      request_v     = v;
      pipe_enq__RDY = prdy;
      #1;
      full = q.size() == DEPTH;
      best = -1;
      for (int i = 0; i < NCHAN; i++) begin
         blk = 1'b0;
         for (int j = 0; j < NCHAN; j++) if (ena[j] && pos(j) < pos(i)) blk = 1'b1;
         er[i] = !full && !blk;
         if (ena[i] && (best < 0 || pos(i) < pos(best))) best = i;
      end
      chk("rdy", 64'(request_RDY), 64'(er));
      chk("count", 64'(count), 64'(q.size()));
      chk("valid", 64'(pipe_enq__ENA), 64'(q.size() != 0));
      if (q.size() != 0) chk("word", 64'(pipe_enq_v), 64'(q[0]));
      if (q.size() != 0 && prdy) void'(q.pop_front());
      if (best >= 0 && !full) begin
         q.push_back({TAG_W'(TAG_BASE + best), v[best*DATA_W +: DATA_W]});
         rr = (best + 1) % NCHAN;
      end
   endtask

   task automatic do_reset();
      @(negedge CLK);
      request_ENA   = '0;
      pipe_enq__RDY = 1'b0;
      nRST          = 1'b0;
      #1;
      chk("rst_valid", 64'(pipe_enq__ENA), 64'h0);
      chk("rst_count", 64'(count), 64'h0);
      chk("rst_rdy", 64'(request_RDY), 64'hF);
      q.delete();
      rr = 0;
      @(negedge CLK);
      nRST = 1'b1;
   endtask

   initial begin
      repeat (2) @(posedge CLK);
      @(negedge CLK) nRST = 1'b1;
      step(4'h0, 64'h0, 1'b1);
      step(4'h1, 64'h11, 1'b1);
      step(4'h0, 64'h0, 1'b1);
      step(4'h0, 64'h0, 1'b1);
      repeat (6) step(4'h3, 64'h000B_000A, 1'b1);
      repeat (2) step(4'h0, 64'h0, 1'b1);
      for (int i = 0; i < 6; i++) step(4'h1, 64'(i + 32), 1'b0);
      step(4'h2, 64'h0055_0000, 1'b1);
      step(4'h2, 64'h0056_0000, 1'b1);
      repeat (6) step(4'h0, 64'h0, 1'b1);
      repeat (6) step(4'hA, 64'h00D3_0000_00B1_0000, 1'b1);
      repeat (2) step(4'h0, 64'h0, 1'b1);
      repeat (3) step(4'h4, {$urandom, $urandom}, 1'b0);
      do_reset();
      repeat (2) step(4'h0, 64'h0, 1'b1);
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 99) == 0) do_reset();
         step(4'($urandom), {$urandom, $urandom}, $urandom_range(0, 3) != 0);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
